// File: rtl/fpu_pkg.sv
// Shared FPU definitions.
//   fpuOp_t        : operation select for the add/sub datapath
//   EXT_SIG_WIDTH  : significand width inside the aligner {hidden, frac, G, R, S}
//   alignState_t   : operand aligner FSM states
package fpu_pkg;

  typedef enum logic [1:0] {
    FPU_ADD = 2'd0,
    FPU_SUB = 2'd1
  } fpuOp_t;

  localparam int FP_SIG_WIDTH  = 10;
  localparam int EXT_SIG_WIDTH = FP_SIG_WIDTH + 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    CLAMP = 2'd2,
    DONE  = 2'd3
  } alignState_t;

endpackage

// File: rtl/fpu_sticky_shifter.sv
// Combinational right shift by a small amount with sticky collection.
//   data_i : significand {hidden, frac, G, R, S}
//   amt_i  : shift amount, 0..STEP
//   data_o : data_i >> amt_i, with every bit shifted out OR-ed into bit 0
module fpu_sticky_shifter #(
  parameter int WIDTH = 14,
  parameter int STEP  = 4
) (
  input  logic [WIDTH-1:0]             data_i,
  input  logic [$clog2(STEP+1)-1:0]    amt_i,
  output logic [WIDTH-1:0]             data_o
);

  logic [WIDTH-1:0] shifted;
  logic             lost;

  always_comb begin
    shifted = data_i >> amt_i;
    lost    = 1'b0;
    // Bits below the shift amount fall off the end; bit 0 is the old sticky,
    // so it is included whenever amt_i > 0.
    for (int i = 0; i < WIDTH; i++) begin
      if (i < int'(amt_i)) lost = lost | data_i[i];
    end
    data_o = {shifted[WIDTH-1:1], shifted[0] | lost};
  end

endmodule

// File: rtl/fpu_aligner.sv
// Operand aligner for the FPU add/sub datapath.
// Unpacks two half-precision operands, orders them by magnitude and
// right-shifts the smaller significand (iteratively, SHIFT_STEP bits/cycle)
// by the exponent difference, tracking guard/round/sticky.
//   clock, reset          : clock, synchronous active-high reset
//   op, opA, opB, inValid : operand request; inReady high in IDLE
//   outValid, outReady    : aligned result handshake; outValid high in DONE
//   bigSig, smallSig      : aligned significands {hidden, frac, G, R, S}
//   alignExp              : effective exponent of the larger operand
//   bigSign, effSub       : result sign candidate, effective subtraction
//   swapped, special      : B was larger, an operand is Inf/NaN
//   dbgState              : current FSM state
//
// Handshake: a transfer happens on a rising edge where valid && ready.
// The producer holds its data stable while valid && !ready; valid never
// depends combinationally on ready in either direction.
module fpu_aligner
  import fpu_pkg::*;
#(
  parameter int BIT_WIDTH  = 16,
  parameter int EXP_WIDTH  = 5,
  parameter int SIG_WIDTH  = 10,
  parameter int SHIFT_STEP = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  fpuOp_t                 op,
  input  logic [BIT_WIDTH-1:0]   opA,
  input  logic [BIT_WIDTH-1:0]   opB,
  input  logic                   inValid,
  output logic                   inReady,
  output logic                   outValid,
  input  logic                   outReady,
  output logic [SIG_WIDTH+3:0]   bigSig,
  output logic [SIG_WIDTH+3:0]   smallSig,
  output logic [EXP_WIDTH-1:0]   alignExp,
  output logic                   bigSign,
  output logic                   effSub,
  output logic                   swapped,
  output logic                   special,
  output alignState_t            dbgState
);

  localparam int EXT   = SIG_WIDTH + 4;
  localparam int AMT_W = $clog2(SHIFT_STEP + 1);

  // ---- unpack ----
  logic                 sign_a, sign_b, hid_a, hid_b, is_sub, a_big, acc_special;
  logic [EXP_WIDTH-1:0] exp_a, exp_b, eff_a, eff_b, diff;
  logic [SIG_WIDTH-1:0] frac_a, frac_b;
  logic [EXP_WIDTH+SIG_WIDTH:0] mag_a, mag_b;
  logic [EXT-1:0]       sig_a, sig_b;

  always_comb begin
    sign_a = opA[BIT_WIDTH-1];
    sign_b = opB[BIT_WIDTH-1];
    exp_a  = opA[BIT_WIDTH-2 -: EXP_WIDTH];
    exp_b  = opB[BIT_WIDTH-2 -: EXP_WIDTH];
    frac_a = opA[SIG_WIDTH-1:0];
    frac_b = opB[SIG_WIDTH-1:0];
    hid_a  = |exp_a;
    hid_b  = |exp_b;
    // Subnormals and zero share the exponent of the smallest normal.
    eff_a  = hid_a ? exp_a : EXP_WIDTH'(1);
    eff_b  = hid_b ? exp_b : EXP_WIDTH'(1);
    mag_a  = {eff_a, hid_a, frac_a};
    mag_b  = {eff_b, hid_b, frac_b};
    sig_a  = {hid_a, frac_a, 3'b000};
    sig_b  = {hid_b, frac_b, 3'b000};
    a_big  = (mag_a >= mag_b);
    diff   = a_big ? (eff_a - eff_b) : (eff_b - eff_a);
    is_sub = (op == FPU_SUB);
    acc_special = (&exp_a) | (&exp_b);
  end

  // ---- state ----
  alignState_t          state_q, state_d;
  logic [EXT-1:0]       big_q, big_d, small_q, small_d, small_shifted;
  logic [EXP_WIDTH-1:0] exp_q, exp_d, rem_q, rem_d;
  logic                 sign_q, sign_d, eff_sub_q, eff_sub_d;
  logic                 swapped_q, swapped_d, special_q, special_d;
  logic [AMT_W-1:0]     amt;

  always_comb begin
    amt = (rem_q > EXP_WIDTH'(SHIFT_STEP)) ? AMT_W'(SHIFT_STEP) : rem_q[AMT_W-1:0];
  end

  fpu_sticky_shifter #(
    .WIDTH (EXT),
    .STEP  (SHIFT_STEP)
  ) u_shifter (
    .data_i (small_q),
    .amt_i  (amt),
    .data_o (small_shifted)
  );

  always_comb begin
    state_d   = state_q;
    big_d     = big_q;
    small_d   = small_q;
    exp_d     = exp_q;
    rem_d     = rem_q;
    sign_d    = sign_q;
    eff_sub_d = eff_sub_q;
    swapped_d = swapped_q;
    special_d = special_q;
    case (state_q)
      IDLE: begin
        if (inValid) begin
          big_d     = a_big ? sig_a : sig_b;
          small_d   = a_big ? sig_b : sig_a;
          exp_d     = a_big ? eff_a : eff_b;
          rem_d     = diff;
          sign_d    = a_big ? sign_a : (sign_b ^ is_sub);
          eff_sub_d = sign_a ^ sign_b ^ is_sub;
          swapped_d = ~a_big;
          special_d = acc_special;
          if (acc_special || diff == '0)         state_d = DONE;
          else if (diff >= EXP_WIDTH'(EXT))      state_d = CLAMP;
          else                                   state_d = SHIFT;
        end
      end
      SHIFT: begin
        small_d = small_shifted;
        rem_d   = rem_q - EXP_WIDTH'(amt);
        if (rem_d == '0) state_d = DONE;
      end
      CLAMP: begin
        // Everything shifts out; only the sticky survives.
        small_d    = '0;
        small_d[0] = |small_q;
        state_d    = DONE;
      end
      DONE: begin
        if (outReady) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      big_q     <= '0;
      small_q   <= '0;
      exp_q     <= '0;
      rem_q     <= '0;
      sign_q    <= 1'b0;
      eff_sub_q <= 1'b0;
      swapped_q <= 1'b0;
      special_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      big_q     <= big_d;
      small_q   <= small_d;
      exp_q     <= exp_d;
      rem_q     <= rem_d;
      sign_q    <= sign_d;
      eff_sub_q <= eff_sub_d;
      swapped_q <= swapped_d;
      special_q <= special_d;
    end
  end

  assign inReady  = (state_q == IDLE);
  assign outValid = (state_q == DONE);
  assign bigSig   = big_q;
  assign smallSig = small_q;
  assign alignExp = exp_q;
  assign bigSign  = sign_q;
  assign effSub   = eff_sub_q;
  assign swapped  = swapped_q;
  assign special  = special_q;
  assign dbgState = state_q;

endmodule

// File: tb/tb_fpu_aligner.sv
module tb_fpu_aligner;
  import fpu_pkg::*;

  localparam int STEP = 4;
  localparam int XW   = 45;  // {bigSig14, smallSig14, exp5, sign, effSub, swapped, special, lat8}

  logic         clock = 1'b0;
  logic         reset;
  fpuOp_t       op;
  logic [15:0]  opA, opB;
  logic         inValid, inReady, outValid, outReady;
  logic [13:0]  bigSig, smallSig;
  logic [4:0]   alignExp;
  logic         bigSign, effSub, swapped, special;
  alignState_t  dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  logic [XW-1:0] exp_q[$];

  fpu_aligner #(
    .BIT_WIDTH(16), .EXP_WIDTH(5), .SIG_WIDTH(10), .SHIFT_STEP(STEP)
  ) dut (
    .clock(clock), .reset(reset), .op(op), .opA(opA), .opB(opB),
    .inValid(inValid), .inReady(inReady), .outValid(outValid), .outReady(outReady),
    .bigSig(bigSig), .smallSig(smallSig), .alignExp(alignExp), .bigSign(bigSign),
    .effSub(effSub), .swapped(swapped), .special(special), .dbgState(dbg_state)
  );

  // ---- clock ----
  always #5 clock = ~clock;

  // ---- checking ----
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
    end
  endtask

  // ---- reference model: plain arithmetic on the unpacked fields ----
  function automatic logic [XW-1:0] model(input logic [15:0] a, input logic [15:0] b,
                                          input logic [1:0] opv);
    int ea, eb, fa, fb, ha, hb, effa, effb, maga, magb, siga, sigb;
    int bs, ss, be, se, diff, aligned, lat;
    bit sa, sb, sub, abig, spec, bsign;
    ea = int'(a[14:10]); eb = int'(b[14:10]);
    fa = int'(a[9:0]);   fb = int'(b[9:0]);
    sa = a[15];          sb = b[15];
    ha = (ea != 0) ? 1 : 0;  hb = (eb != 0) ? 1 : 0;
    effa = (ea == 0) ? 1 : ea;  effb = (eb == 0) ? 1 : eb;
    maga = effa * 2048 + ha * 1024 + fa;
    magb = effb * 2048 + hb * 1024 + fb;
    siga = (ha * 1024 + fa) * 8;
    sigb = (hb * 1024 + fb) * 8;
    sub  = (opv == 2'd1);
    abig = (maga >= magb);
    spec = (ea == 31) || (eb == 31);
    bs = abig ? siga : sigb;  ss = abig ? sigb : siga;
    be = abig ? effa : effb;  se = abig ? effb : effa;
    diff = be - se;
    if (spec || diff == 0) begin
      aligned = ss; lat = 1;
    end else if (diff >= 14) begin
      aligned = (ss != 0) ? 1 : 0; lat = 2;
    end else begin
      aligned = (ss >> diff) | (((ss % (1 << diff)) != 0) ? 1 : 0);
      lat = 1 + (diff + STEP - 1) / STEP;
    end
    bsign = abig ? sa : (sb ^ sub);
    return {14'(bs), 14'(aligned), 5'(be), bsign, sa ^ sb ^ sub, ~abig, spec, 8'(lat)};
  endfunction

  task automatic check_fields(input string tag, input logic [XW-1:0] e);
    check({tag, "_bigSig"},   32'(bigSig),   32'(e[44:31]));
    check({tag, "_smallSig"}, 32'(smallSig), 32'(e[30:17]));
    check({tag, "_alignExp"}, 32'(alignExp), 32'(e[16:12]));
    check({tag, "_flags"},    32'({bigSign, effSub, swapped, special}), 32'(e[11:8]));
  endtask

  // ---- driver: one transaction, starting and ending just after a negedge ----
  task automatic run_txn(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic [1:0] opv, input int hold, input bit scramble);
    logic [XW-1:0] e;
    int lat;
    exp_q.push_back(model(a, b, opv));
    opA = a; opB = b; op = fpuOp_t'(opv); inValid = 1'b1;
    check({tag, "_inReady_idle"}, 32'(inReady), 32'd1);
    @(posedge clock);
    @(negedge clock);
    lat = 1;
    while (!outValid && lat < 40) begin
      // Operands change while busy; they must not be recaptured.
      if (scramble) begin
        opA = 16'($urandom_range(0, 16'hFFFF));
        opB = 16'($urandom_range(0, 16'hFFFF));
      end
      @(negedge clock);
      lat++;
    end
    inValid = 1'b0;
    e = exp_q.pop_front();
    check({tag, "_outValid"}, 32'(outValid), 32'd1);
    check({tag, "_latency"}, 32'(lat), 32'(e[7:0]));
    check_fields(tag, e);
    for (int h = 0; h < hold; h++) begin
      @(negedge clock);
      check({tag, "_hold_valid"}, 32'({outValid, inReady}), 32'b10);
      check_fields({tag, "_hold"}, e);
    end
    outReady = 1'b1;
    @(negedge clock);
    outReady = 1'b0;
    check({tag, "_release"}, 32'({outValid, inReady}), 32'b01);
  endtask

  function automatic logic [15:0] rand_operand(input int mode, input int base_exp);
    int e;
    case (mode)
      0: e = $urandom_range(0, 31);
      1: e = base_exp + $urandom_range(0, 6) - 3;
      2: e = base_exp + $urandom_range(0, 20) - 10;
      default: e = ($urandom_range(0, 1) != 0) ? 0 : 1;
    endcase
    if (e < 0) e = 0;
    if (e > 30 && mode != 0) e = 30;
    return {1'($urandom_range(0, 1)), 5'(e), 10'($urandom_range(0, 1023))};
  endfunction

  // ---- main sequence ----
  initial begin
    logic seen;
    int mode, base;
    reset = 1'b1; op = FPU_ADD; opA = '0; opB = '0;
    inValid = 1'b0; outReady = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_outputs", 32'({bigSig, smallSig}), 32'd0);
    check("rst_misc", 32'({alignExp, bigSign, effSub, swapped, special, outValid}), 32'd0);
    reset = 1'b0;
    @(negedge clock);
    check("rst_inReady", 32'(inReady), 32'd1);
    check("rst_state", 32'(dbg_state), 32'(IDLE));

    // Directed cases
    run_txn("eq",      16'h3C00, 16'h3C00, 2'd0, 0, 1'b0);
    run_txn("diff4",   16'h4C00, 16'h3C01, 2'd0, 0, 1'b0);
    run_txn("diff10",  16'h3C00, 16'h6400, 2'd1, 1, 1'b0);
    run_txn("clamp",   16'h7800, 16'h3C01, 2'd0, 0, 1'b0);
    run_txn("subn",    16'h0001, 16'h0400, 2'd0, 0, 1'b0);
    run_txn("special", 16'h7C00, 16'h3C00, 2'd0, 5, 1'b0);
    run_txn("zeros",   16'h0000, 16'h8000, 2'd1, 0, 1'b0);
    run_txn("badop",   16'hBC00, 16'h3800, 2'd3, 0, 1'b1);

    // Reset during the second SHIFT cycle of the diff-10 case
    opA = 16'h3C00; opB = 16'h6400; op = FPU_SUB; inValid = 1'b1;
    @(posedge clock);
    @(negedge clock);
    inValid = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("midrst_hs", 32'({outValid, inReady}), 32'b01);
    check("midrst_sigs", 32'({bigSig, smallSig}), 32'd0);
    check("midrst_misc", 32'({alignExp, bigSign, effSub, swapped, special}), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      if (outValid) seen = 1'b1;
    end
    check("midrst_no_stale", 32'(seen), 32'd0);

    // Randomized traffic
    for (int t = 0; t < 250; t++) begin
      mode = $urandom_range(0, 3);
      base = $urandom_range(0, 30);
      run_txn("rnd", rand_operand(mode, base), rand_operand(mode, base),
              2'($urandom_range(0, 3)), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) @(negedge clock);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fpu_aligner.md
Name: fpu_aligner

Overview:
- Operand aligner: the input-side counterpart of the post-operation normalizer in the FPU add/sub datapath.
- Accepts two packed half-precision operands and unpacks them (hidden bit, subnormals).
- Orders them by magnitude, then right-shifts the smaller significand by the exponent difference. Shifting is iterative, up to SHIFT_STEP bits per cycle, with guard/round/sticky tracking.
- Presents both aligned significands and the common exponent to the significand adder over a valid/ready handshake.

Parameters:
BIT_WIDTH, 16, packed operand width
EXP_WIDTH, 5, exponent field width
SIG_WIDTH, 10, stored fraction width
SHIFT_STEP, 4, maximum right-shift bits per SHIFT cycle (1..SIG_WIDTH+4)

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high reset
op  input  fpuOp_t  FPU_ADD or FPU_SUB; any other value is treated as FPU_ADD
opA  input  BIT_WIDTH  packed operand A
opB  input  BIT_WIDTH  packed operand B
inValid  input  1  operands valid
inReady  output  1  aligner can accept; equals (state==IDLE)
outValid  output  1  aligned result valid; equals (state==DONE)
outReady  input  1  consumer accepts result
bigSig  output  SIG_WIDTH+4  larger-magnitude significand {hidden, frac, 3'b000}
smallSig  output  SIG_WIDTH+4  smaller significand, aligned {hidden, frac, G, R, S}
alignExp  output  EXP_WIDTH  effective exponent of the larger operand
bigSign  output  1  sign of the larger operand after op applied (B's sign flipped for SUB)
effSub  output  1  signA ^ signB ^ (op==FPU_SUB)
swapped  output  1  1 when B is the larger magnitude
special  output  1  either operand has exponent all-ones (Inf/NaN); adder must bypass

Behaviour:
- Interface: one clock, `clock`; reset `reset` is synchronous and active-high.
- On reset: state=IDLE. All registered outputs (bigSig, smallSig, alignExp, bigSign, effSub, swapped, special) are 0. outValid=0, inReady=1 from the first cycle after reset deasserts.
- Reset mid-operation abandons the operation. The next cycle shows IDLE with outValid=0, and no result is ever emitted.
- Unpack:
  - exp==0 → hidden=0, effective exp=1 (subnormal/zero).
  - Otherwise hidden=1, effective exp=exp.
- Magnitude compare uses {effective exp, hidden, frac}. On equality A is big (swapped=0).
- diff = effExpBig − effExpSmall (EXP_WIDTH bits, never negative).
- Accept on inValid && inReady. On that edge, register unpacked big/small, sign/effSub/swapped/special, and remaining=diff. Next state:
  - special=1 → DONE
  - else diff==0 → DONE
  - else diff ≥ SIG_WIDTH+4 → CLAMP
  - else SHIFT
- SHIFT: each cycle, amt = min(remaining, SHIFT_STEP).
  - smallSig ← smallSig >> amt, with bit 0 (S) ← old S | OR of all bits shifted out.
  - remaining ← remaining − amt.
  - Go to DONE when remaining reaches 0.
- CLAMP, one cycle: smallSig ← {0…0, |smallSig}; alignment is complete in DONE on the next cycle.
- Latency from the accept edge to outValid high:
  - 1 cycle when diff==0 or special=1
  - 1 + ceil(diff/SHIFT_STEP) cycles for the SHIFT path
  - 2 cycles for the CLAMP path
- DONE: outputs hold stable while outValid && !outReady. On outValid && outReady → IDLE next cycle. There is no same-cycle re-accept (inReady=0 in DONE).
- inValid while not IDLE is ignored. Operands are not captured, and the upstream must hold them.
- special=1: bigSig/smallSig carry the unpacked operands unshifted. NaN/Inf decode is the consumer's responsibility.
- Zero operands follow the normal path; no special case.

Decomposition:
- fpu_pkg (shared):
  - existing fpuOp_t (FPU_ADD, FPU_SUB)
  - localparam EXT_SIG_WIDTH = SIG_WIDTH+4
  - alignState_t enum {IDLE, SHIFT, CLAMP, DONE}
- Sub-module fpu_sticky_shifter: combinational right shift of an EXT_SIG_WIDTH vector by amt ≤ SHIFT_STEP, OR-ing shifted-out bits into bit 0. It is instantiated once in the SHIFT datapath.

Test Plan:
- A=0x3C00, B=0x3C00, FPU_ADD → outValid 1 cycle after accept; bigSig=0x2000, smallSig=0x2000, alignExp=15, effSub=0, swapped=0.
- A=0x4C00, B=0x3C01, FPU_ADD (diff 4, one SHIFT) → outValid 2 cycles after accept; smallSig=0x0201 (sticky set), bigSig=0x2000, alignExp=19.
- A=0x3C00, B=0x6400, FPU_SUB (diff 10: shifts 4,4,2) → outValid 4 cycles after accept; swapped=1, smallSig=0x0008, alignExp=25, effSub=1, bigSign=1.
- A=0x7800, B=0x3C01 (diff 15, CLAMP) → outValid 2 cycles after accept; smallSig=0x0001. Then A=0x0001, B=0x0400 → diff 0, swapped=1, bigSig=0x2000, smallSig=0x0008, alignExp=1.
- A=0x7C00, B=0x3C00 → special=1, outValid 1 cycle after accept. Hold outReady=0 for 5 cycles → all outputs stable and inReady=0. Pulse outReady → next cycle IDLE, inReady=1.
- Start the diff-10 case, assert reset in the 2nd SHIFT cycle → next cycle outValid=0, inReady=1, outputs 0; no stale result appears afterwards.
